// File: rtl/pingpong_trans_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_trans_ctrl
// Description : Ping-pong matrix transposer controller. A ROWS x COLS matrix
//               arriving row-major on the input stream is written into one
//               single-port RAM bank. Meanwhile the other bank is read
//               column-major and sent to the output stream. The two banks
//               swap roles when a whole matrix has been written or fully
//               drained.
//
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               s_valid/s_ready/s_data         - row-major input stream
//               m_valid/m_ready/m_data/m_last  - column-major output stream
//               ramN_en/we/addr/din  - bank N control (N = 0, 1)
//               ramN_dout            - bank N read data, one cycle after read
//
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_trans_ctrl #(
    parameter int ROWS_LOG2  = 3,
    parameter int COLS_LOG2  = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,

    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,

    output logic                  ram0_en,
    output logic                  ram0_we,
    output logic [ADDR_WIDTH-1:0] ram0_addr,
    output logic [DATA_WIDTH-1:0] ram0_din,
    input  logic [DATA_WIDTH-1:0] ram0_dout,

    output logic                  ram1_en,
    output logic                  ram1_we,
    output logic [ADDR_WIDTH-1:0] ram1_addr,
    output logic [DATA_WIDTH-1:0] ram1_din,
    input  logic [DATA_WIDTH-1:0] ram1_dout
);

    localparam logic [ROWS_LOG2-1:0] c_ROW_LAST = {ROWS_LOG2{1'b1}};
    localparam logic [COLS_LOG2-1:0] c_COL_LAST = {COLS_LOG2{1'b1}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]           r_full;      // bank holds a complete, undrained matrix
    logic                 r_wbank;     // bank currently being written
    logic                 r_rbank;     // bank currently being read
    logic [ROWS_LOG2-1:0] r_wr_row;
    logic [COLS_LOG2-1:0] r_wr_col;
    logic [ROWS_LOG2-1:0] r_rd_row;
    logic [COLS_LOG2-1:0] r_rd_col;
    logic                 r_rd_done;   // every element of the read bank issued
    logic                 r_dbank;     // bank whose dout feeds m_data
    logic                 r_m_valid;
    logic                 r_m_last;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic                  w_accept;
    logic                  w_wr_last;
    logic                  w_issue;
    logic                  w_rd_last;
    logic                  w_release;
    logic [1:0]            w_full_set;
    logic [1:0]            w_full_clr;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    assign s_ready   = !r_full[r_wbank];
    assign w_accept  = s_valid & s_ready;
    assign w_wr_last = (r_wr_row == c_ROW_LAST) && (r_wr_col == c_COL_LAST);

    // A new read may only be launched when the output register is empty or
    // is being emptied this cycle; while stalled no read is issued, so the
    // RAM dout (and therefore m_data) holds its value.
    assign w_issue   = r_full[r_rbank] & !r_rd_done & (!r_m_valid | m_ready);
    assign w_rd_last = (r_rd_row == c_ROW_LAST) && (r_rd_col == c_COL_LAST);

    // The final element of a matrix leaving the output frees its bank.
    assign w_release = r_m_valid & m_ready & r_m_last;

    assign w_wr_addr = {r_wr_row, r_wr_col};
    assign w_rd_addr = {r_rd_row, r_rd_col};

    // Set needs !full and clear needs full on the same bit, so a bit is
    // never set and cleared together; the two banks can change at once.
    assign w_full_set = (w_accept & w_wr_last) ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_clr = w_release              ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;

    // ------------------------------------------------------------------------
    // Write side: row-major counters, column fastest
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_row <= '0;
            r_wr_col <= '0;
            r_wbank  <= 1'b0;
        end else if (w_accept) begin
            if (w_wr_last) begin
                r_wr_row <= '0;
                r_wr_col <= '0;
                r_wbank  <= ~r_wbank;
            end else begin
                r_wr_col <= r_wr_col + 1'b1;
                if (r_wr_col == c_COL_LAST) begin
                    r_wr_row <= r_wr_row + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bank occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

    // ------------------------------------------------------------------------
    // Read side: column-major counters, row fastest
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_row  <= '0;
            r_rd_col  <= '0;
            r_rd_done <= 1'b0;
            r_rbank   <= 1'b0;
        end else if (w_release) begin
            // The next matrix can issue no earlier than the following cycle
            // because r_rbank only points at it from then on.
            r_rd_row  <= '0;
            r_rd_col  <= '0;
            r_rd_done <= 1'b0;
            r_rbank   <= ~r_rbank;
        end else if (w_issue) begin
            if (w_rd_last) begin
                r_rd_row  <= '0;
                r_rd_col  <= '0;
                r_rd_done <= 1'b1;
            end else begin
                r_rd_row <= r_rd_row + 1'b1;
                if (r_rd_row == c_ROW_LAST) begin
                    r_rd_col <= r_rd_col + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register: tracks the element sitting on the RAM dout
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_dbank   <= 1'b0;
        end else begin
            r_m_valid <= w_issue | (r_m_valid & !m_ready);
            if (w_issue) begin
                r_dbank  <= r_rbank;
                r_m_last <= w_rd_last;
            end else if (w_release) begin
                r_m_last <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign m_data  = r_dbank ? ram1_dout : ram0_dout;

    // ------------------------------------------------------------------------
    // RAM control. A write targets a non-full bank and a read targets a full
    // one, so both branches never land on the same bank in one cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        ram0_en   = 1'b0;
        ram0_we   = 1'b0;
        ram0_addr = '0;
        ram0_din  = s_data;
        ram1_en   = 1'b0;
        ram1_we   = 1'b0;
        ram1_addr = '0;
        ram1_din  = s_data;

        if (w_accept) begin
            if (r_wbank) begin
                ram1_en   = 1'b1;
                ram1_we   = 1'b1;
                ram1_addr = w_wr_addr;
            end else begin
                ram0_en   = 1'b1;
                ram0_we   = 1'b1;
                ram0_addr = w_wr_addr;
            end
        end

        if (w_issue) begin
            if (r_rbank) begin
                ram1_en   = 1'b1;
                ram1_addr = w_rd_addr;
            end else begin
                ram0_en   = 1'b1;
                ram0_addr = w_rd_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pingpong_trans_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pingpong_trans_ctrl
// Description : Self-checking bench for pingpong_trans_ctrl. Two behavioural
//               single-port RAMs sit on the bank ports; a matrix-level model
//               (buffer, transpose queue, occupancy count) predicts every
//               output element, s_ready and the RAM bank usage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_trans_ctrl;

    localparam int RL = 3;
    localparam int CL = 4;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int NC = 16;
    localparam int N  = NR * NC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic          ram0_en, ram0_we, ram1_en, ram1_we;
    logic [AW-1:0] ram0_addr, ram1_addr;
    logic [DW-1:0] ram0_din, ram1_din, ram0_dout, ram1_dout;

    always #5 clk = ~clk;

    pingpong_trans_ctrl #(
        .ROWS_LOG2 (RL),
        .COLS_LOG2 (CL),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .ram0_en  (ram0_en),
        .ram0_we  (ram0_we),
        .ram0_addr(ram0_addr),
        .ram0_din (ram0_din),
        .ram0_dout(ram0_dout),
        .ram1_en  (ram1_en),
        .ram1_we  (ram1_we),
        .ram1_addr(ram1_addr),
        .ram1_din (ram1_din),
        .ram1_dout(ram1_dout)
    );

    // Behavioural single-port RAMs: write has priority, dout untouched on write
    logic [DW-1:0] mem0 [N];
    logic [DW-1:0] mem1 [N];
    always @(posedge clk) begin
        if (ram0_en) begin
            if (ram0_we) mem0[ram0_addr] <= ram0_din;
            else         ram0_dout       <= mem0[ram0_addr];
        end
        if (ram1_en) begin
            if (ram1_we) mem1[ram1_addr] <= ram1_din;
            else         ram1_dout       <= mem1[ram1_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    bit abort  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Matrix-level reference model
    // ------------------------------------------------------------------------
    logic [DW-1:0] mbuf [N];
    int            in_cnt, n_full, wmat, rmat, out_idx, lasts_seen;
    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];
    bit            prev_stall;
    logic [DW-1:0] out_log [N];
    int            cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        bit acc, hs, rd0, rd1;
        if (!rst_n) begin
            in_cnt = 0; n_full = 0; wmat = 0; rmat = 0; out_idx = 0;
            lasts_seen = 0; prev_stall = 0;
            exp_d.delete(); exp_l.delete();
        end else begin
            acc = s_valid && s_ready;
            hs  = m_valid && m_ready;
            rd0 = ram0_en && !ram0_we;
            rd1 = ram1_en && !ram1_we;

            chk("s_ready", s_ready, n_full < 2);
            if (prev_stall) chk("m_valid_hold", m_valid, 1);
            if (m_valid) begin
                if (exp_d.size() == 0) chk("spurious_m_valid", 1, 0);
                else begin
                    chk("m_data", m_data, exp_d[0]);
                    chk("m_last", m_last, exp_l[0]);
                end
            end
            chk("wr_strobe", {ram0_we, ram1_we}, acc ? ((wmat % 2) ? 2'b01 : 2'b10) : 2'b00);
            if (acc) begin
                chk("wr_addr", (wmat % 2) ? ram1_addr : ram0_addr, in_cnt);
                chk("wr_din",  (wmat % 2) ? ram1_din  : ram0_din,  s_data);
            end
            if (rd0 || rd1) chk("rd_bank", {rd0, rd1}, (rmat % 2) ? 2'b01 : 2'b10);
            if (m_valid && !m_ready) chk("rd_while_stalled", rd0 | rd1, 0);

            prev_stall = m_valid && !m_ready;
            if (hs && exp_d.size() > 0) begin
                if (out_idx < N) out_log[out_idx] = m_data;
                out_idx++;
                if (m_last) lasts_seen++;
                if (exp_l[0]) begin
                    n_full--;
                    rmat++;
                end
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
            end
            if (acc) begin
                mbuf[in_cnt] = s_data;
                in_cnt++;
                if (in_cnt == N) begin
                    for (int c = 0; c < NC; c++)
                        for (int r = 0; r < NR; r++) begin
                            exp_d.push_back(mbuf[r*NC + c]);
                            exp_l.push_back(c == NC-1 && r == NR-1);
                        end
                    in_cnt = 0;
                    n_full++;
                    wmat++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Downstream ready driver: 0 always, 1 never, 2 random 70%, 3 stall at idx 1
    // ------------------------------------------------------------------------
    int rdy_mode   = 0;
    int stall_left = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'b0;
            2: m_ready = ($urandom_range(0, 99) < 70);
            default: begin
                if (out_idx == 1 && stall_left > 0) begin
                    m_ready = 1'b0;
                    stall_left--;
                end else begin
                    m_ready = 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------------
    task automatic send_elem(input logic [DW-1:0] d, input int idle_pct);
        int t;
        if (abort) return;
        while (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        t = 0;
        while (!s_ready) begin
            @(posedge clk); #1;
            t++;
            if (t > 3000) begin
                chk("s_ready_timeout", 0, 1);
                abort   = 1;
                s_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_matrix(input bit rnd, input int idle_pct);
        for (int i = 0; i < N; i++)
            send_elem(rnd ? DW'($urandom) : DW'(i), idle_pct);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_d.size() != 0 || m_valid) && t < 4000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_timeout", t < 4000, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, sc;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last",  m_last,  0);
        chk("rst_ram_en",  {ram0_en, ram1_en}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single matrix, element value = r*16+c, latency and order pinned
        rdy_mode = 0;
        send_matrix(0, 0);
        chk("lat_t1_m_valid", m_valid, 0);
        @(posedge clk); #1;
        chk("lat_t2_m_valid", m_valid, 1);
        chk("lat_t2_m_data",  m_data,  0);
        drain();
        chk("t1_count", out_idx, 128);
        chk("t1_out0",  out_log[0],   0);
        chk("t1_out1",  out_log[1],   16);
        chk("t1_out7",  out_log[7],   112);
        chk("t1_out8",  out_log[8],   1);
        chk("t1_out9",  out_log[9],   17);
        chk("t1_out127", out_log[127], 127);
        chk("t1_lasts", lasts_seen, 1);

        // Three back-to-back matrices, continuous input
        do_reset();
        rdy_mode = 0;
        start = cyc;
        send_matrix(1, 0);
        send_matrix(1, 0);
        chk("t2_two_matrix_cycles", cyc - start, 256);
        send_matrix(1, 0);
        drain();
        chk("t2_count", out_idx, 384);
        chk("t2_lasts", lasts_seen, 3);

        // Five-cycle downstream stall on the element with value 16
        do_reset();
        stall_left = 5;
        rdy_mode   = 3;
        send_matrix(0, 0);
        sc = 0;
        for (int t = 0; t < 400 && out_idx < 3; t++) begin
            @(negedge clk);
            if (m_valid && !m_ready) begin
                sc++;
                chk("t3_stall_data", m_data, 16);
            end
        end
        chk("t3_stall_cycles", sc, 5);
        drain();
        chk("t3_out1", out_log[1], 16);
        chk("t3_out2", out_log[2], 32);
        chk("t3_count", out_idx, 128);
        rdy_mode = 0;

        // Downstream blocked: both banks fill, input must stall
        do_reset();
        rdy_mode = 1;
        send_matrix(1, 0);
        send_matrix(1, 0);
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            chk("t4_s_ready_blocked", s_ready, 0);
        end
        s_valid  = 1'b0;
        rdy_mode = 0;
        send_matrix(1, 0);
        drain();
        chk("t4_count", out_idx, 384);

        // Random valid/ready over ten matrices
        do_reset();
        rdy_mode = 2;
        for (int m = 0; m < 10; m++) send_matrix(1, 30);
        rdy_mode = 0;
        drain();
        chk("t5_count", out_idx, 1280);
        chk("t5_lasts", lasts_seen, 10);

        // Asynchronous reset mid-write, then mid-read
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 60; i++) send_elem(DW'($urandom), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_wr_rst_s_ready", s_ready, 1);
        chk("t6_wr_rst_ram_we",  {ram0_we, ram1_we}, 2'b00);
        @(posedge clk); #3;
        rst_n = 1'b1;
        rdy_mode = 1;
        @(posedge clk); #1;
        send_matrix(1, 0);
        send_matrix(1, 0);
        chk("t6_full_s_ready", s_ready, 0);
        chk("t6_pre_m_valid",  m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rd_rst_s_ready", s_ready, 1);
        chk("t6_rd_rst_m_valid", m_valid, 0);
        chk("t6_rd_rst_m_last",  m_last,  0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk); #1;
        send_matrix(0, 0);
        drain();
        chk("t6_count", out_idx, 128);
        chk("t6_out1",  out_log[1], 16);
        chk("t6_out127", out_log[127], 127);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
